// File: rtl/adder_pkg.sv
// Shared sizing constants and helpers for the pipelined add/subtract unit.
package adder_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_SLICE = 4;

    // Number of pipeline stages: one per SLICE-bit group of the operand.
    function automatic int unsigned n_stages(input int unsigned width, input int unsigned slice);
        return (slice == 0) ? 32'd1 : width / slice;
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Valid/ready operand and result bus of the pipelined adder.
interface pipelined_adder_if #(
    parameter int unsigned WIDTH = adder_pkg::DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, A, B, cin, sub, out_ready,
        input  in_ready, out_valid, S, cout, ovf
    );

    modport slave (
        input  in_valid, A, B, cin, sub, out_ready,
        output in_ready, out_valid, S, cout, ovf
    );
endinterface

// File: rtl/ripple_slice.sv
// Combinational SLICE-bit ripple-carry adder used once per pipeline stage.
module ripple_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] s_o,
    output logic             cout_o
);
    logic carry;

    always_comb begin
        s_o   = '0;
        carry = cin_i;
        for (int unsigned i = 0; i < SLICE; i++) begin
            s_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one SLICE-bit ripple slice per stage, carry registered between
// stages, whole pipe advances together under output back-pressure.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SLICE = DEF_SLICE
) (
    input  logic             Clk,
    input  logic             Reset,
    pipelined_adder_if.slave bus
);
    localparam int unsigned STAGES = n_stages(WIDTH, SLICE);
    localparam int unsigned MSB    = WIDTH - 1;

    typedef struct packed {
        logic             v;
        logic             c;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             amsb;
        logic             bmsb;
        logic             ovf;
    } stage_t;

    if ((SLICE == 0) || ((WIDTH % SLICE) != 0)) begin : g_cfg_check
        $error("pipelined_adder: WIDTH (%0d) must be a non-zero multiple of SLICE (%0d)", WIDTH, SLICE);
    end

    stage_t           st_d [STAGES];
    stage_t           st_q [STAGES];
    logic             advance_c;
    logic             accept_c;
    logic [WIDTH-1:0] b_eff_c;

    assign advance_c = ~st_q[STAGES-1].v | bus.out_ready;
    assign accept_c  = bus.in_valid & advance_c;
    assign b_eff_c   = bus.sub ? ~bus.B : bus.B;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t           st_in;
        logic [SLICE-1:0] sum_c;
        logic             carry_c;
        logic [WIDTH-1:0] s_next_c;

        // Stage 0 takes the bus (subtract = add inverted B with carry-in 1).
        if (k == 0) begin : g_head
            assign st_in = '{v: accept_c, c: bus.sub | bus.cin, a: bus.A, b: b_eff_c, s: '0,
                             amsb: bus.A[MSB], bmsb: b_eff_c[MSB], ovf: 1'b0};
        end else begin : g_tail
            assign st_in = st_q[k-1];
        end

        ripple_slice #(.SLICE(SLICE)) u_slice (
            .a_i    (st_in.a[k*SLICE +: SLICE]),
            .b_i    (st_in.b[k*SLICE +: SLICE]),
            .cin_i  (st_in.c),
            .s_o    (sum_c),
            .cout_o (carry_c)
        );

        always_comb begin
            s_next_c                   = st_in.s;
            s_next_c[k*SLICE +: SLICE] = sum_c;
        end

        // Overflow is only meaningful once the top slice has been resolved (last stage).
        assign st_d[k] = '{v: st_in.v, c: carry_c, a: st_in.a, b: st_in.b, s: s_next_c,
                           amsb: st_in.amsb, bmsb: st_in.bmsb,
                           ovf: (st_in.amsb == st_in.bmsb) & (s_next_c[MSB] != st_in.amsb)};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned k = 0; k < STAGES; k++) st_q[k] <= '0;
        end else if (advance_c) begin
            for (int unsigned k = 0; k < STAGES; k++) st_q[k] <= st_d[k];
        end
    end

    assign bus.in_ready  = advance_c;
    assign bus.out_valid = st_q[STAGES-1].v;
    assign bus.S         = st_q[STAGES-1].s;
    assign bus.cout      = st_q[STAGES-1].c;
    assign bus.ovf       = st_q[STAGES-1].ovf;
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: 16/4 instance for directed cases, 32/8 instance under random handshakes.
module tb_pipelined_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst16;
    logic rst32;

    pipelined_adder_if #(.WIDTH(16)) b16 ();
    pipelined_adder_if #(.WIDTH(32)) b32 ();

    pipelined_adder #(.WIDTH(16), .SLICE(4)) u_dut16 (.Clk(clk), .Reset(rst16), .bus(b16));
    pipelined_adder #(.WIDTH(32), .SLICE(8)) u_dut32 (.Clk(clk), .Reset(rst32), .bus(b32));

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        lat;
        int          acc;
    } exp_t;

    exp_t q16[$];
    exp_t q32[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic done16   = 1'b0;
    logic done32   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o);
        exp_t e;
        e.s = s; e.cout = c; e.ovf = o; e.lat = 1'b0; e.acc = 0;
        return e;
    endfunction

    // Reference: {cout,S} = A + B' + cin' with B'/cin' after subtract substitution.
    function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        logic [32:0] t;
        logic [31:0] bb;
        bb = sub ? ~b : b;
        t  = 33'(a) + 33'(bb) + 33'(sub | cin);
        return mk(t[31:0], t[32], (a[31] == bb[31]) && (t[31] != a[31]));
    endfunction

    // Scoreboard monitors: compare whenever a result is presented, pop on transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst16 && b16.out_valid) begin
            if (q16.size() == 0) begin
                checks++; failures++;
                $display("FAIL out16_unexpected: got S=%h expected no result", b16.S);
            end else begin
                e = q16[0];
                chk("s16", 32'(b16.S), e.s);
                chk("cout16", 32'(b16.cout), 32'(e.cout));
                chk("ovf16", 32'(b16.ovf), 32'(e.ovf));
                if (b16.out_ready) begin
                    if (e.lat) chk("latency16", 32'(cyc - e.acc), 32'd4);
                    void'(q16.pop_front());
                end else begin
                    chk("stall_in_ready16", 32'(b16.in_ready), 32'd0);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst32 && b32.out_valid) begin
            if (q32.size() == 0) begin
                checks++; failures++;
                $display("FAIL out32_unexpected: got S=%h expected no result", b32.S);
            end else begin
                e = q32[0];
                chk("s32", b32.S, e.s);
                chk("cout32", 32'(b32.cout), 32'(e.cout));
                chk("ovf32", 32'(b32.ovf), 32'(e.ovf));
                if (b32.out_ready) void'(q32.pop_front());
                else chk("stall_in_ready32", 32'(b32.in_ready), 32'd0);
            end
        end
    end

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                          input exp_t e, input logic lat);
        logic ok;
        ok = 1'b0;
        b16.A = a; b16.B = b; b16.cin = cin; b16.sub = sub; b16.in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (b16.in_ready) begin
                e.lat = lat; e.acc = cyc; q16.push_back(e); ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept16_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                          input exp_t e);
        logic ok;
        ok = 1'b0;
        b32.A = a; b32.B = b; b32.cin = cin; b32.sub = sub; b32.in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (b32.in_ready) begin
                e.acc = cyc; q32.push_back(e); ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept32_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
    endtask

    // 16-bit directed sequence.
    initial begin
        logic [15:0] ta [8] = '{16'h0001, 16'h00FF, 16'h0FFF, 16'h8000, 16'hFFFF, 16'h1234, 16'hAAAA, 16'h7FFF};
        logic [15:0] tb [8] = '{16'h0001, 16'h0001, 16'h0001, 16'h8000, 16'hFFFF, 16'h4321, 16'h5555, 16'h7FFF};
        logic [15:0] ts [8] = '{16'h0002, 16'h0100, 16'h1000, 16'h0000, 16'hFFFE, 16'h5555, 16'hFFFF, 16'hFFFE};
        logic        tc [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        to [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        b16.in_valid = 1'b0; b16.A = '0; b16.B = '0; b16.cin = 1'b0; b16.sub = 1'b0; b16.out_ready = 1'b1;
        rst16 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst16 = 1'b0;
        @(negedge clk);
        chk("rst_out_valid16", 32'(b16.out_valid), 32'd0);
        chk("rst_S16", 32'(b16.S), 32'd0);
        chk("rst_cout_ovf16", {30'd0, b16.cout, b16.ovf}, 32'd0);
        chk("rst_in_ready16", 32'(b16.in_ready), 32'd1);
        @(posedge clk); #1;

        send16(16'h0001, 16'h0001, 1'b0, 1'b0, mk(32'h0002, 1'b0, 1'b0), 1'b1);
        send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(32'h0000, 1'b1, 1'b0), 1'b1);
        send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(32'h8000, 1'b0, 1'b1), 1'b1);
        send16(16'h0005, 16'h0007, 1'b0, 1'b1, mk(32'hFFFE, 1'b0, 1'b0), 1'b1);
        send16(16'h0005, 16'h0003, 1'b1, 1'b1, mk(32'h0002, 1'b1, 1'b0), 1'b1);
        repeat (8) @(posedge clk); #1;

        for (int i = 0; i < 8; i++) send16(ta[i], tb[i], 1'b0, 1'b0, mk(32'(ts[i]), tc[i], to[i]), 1'b1);
        repeat (8) @(posedge clk); #1;
        chk("drain_burst16", 32'(q16.size()), 32'd0);

        // Stall the output for three cycles while a fifth op waits at the input.
        b16.out_ready = 1'b0;
        send16(16'h0010, 16'h0020, 1'b0, 1'b0, mk(32'h0030, 1'b0, 1'b0), 1'b0);
        send16(16'h8000, 16'h0001, 1'b0, 1'b1, mk(32'h7FFF, 1'b1, 1'b1), 1'b0);
        send16(16'hFFF0, 16'h0010, 1'b1, 1'b0, mk(32'h0001, 1'b1, 1'b0), 1'b0);
        send16(16'h4000, 16'h4000, 1'b0, 1'b0, mk(32'h8000, 1'b0, 1'b1), 1'b0);
        fork
            begin repeat (3) @(posedge clk); #1 b16.out_ready = 1'b1; end
        join_none
        send16(16'h0100, 16'h0001, 1'b0, 1'b1, mk(32'h00FF, 1'b1, 1'b0), 1'b0);
        repeat (10) @(posedge clk); #1;
        chk("drain_stall16", 32'(q16.size()), 32'd0);

        // Reset with three ops in flight: none may appear afterwards.
        b16.out_ready = 1'b0;
        send16(16'h1111, 16'h1111, 1'b0, 1'b0, mk(32'h2222, 1'b0, 1'b0), 1'b0);
        send16(16'h2222, 16'h1111, 1'b0, 1'b0, mk(32'h3333, 1'b0, 1'b0), 1'b0);
        send16(16'h3333, 16'h1111, 1'b0, 1'b0, mk(32'h4444, 1'b0, 1'b0), 1'b0);
        @(posedge clk); #1;
        rst16 = 1'b1;
        q16.delete();
        @(posedge clk); #1;
        rst16 = 1'b0;
        b16.out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_out_valid16", 32'(b16.out_valid), 32'd0);
        chk("post_rst_in_ready16", 32'(b16.in_ready), 32'd1);
        repeat (8) @(posedge clk); #1;
        send16(16'h1234, 16'h1111, 1'b0, 1'b0, mk(32'h2345, 1'b0, 1'b0), 1'b1);
        for (int n = 0; n < 40 && q16.size() != 0; n++) @(posedge clk);
        #1 chk("drain_final16", 32'(q16.size()), 32'd0);
        done16 = 1'b1;
    end

    // 32-bit sweep with random gaps and random output back-pressure.
    initial begin
        logic [31:0] va [8] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h12345678,
                                32'h00000000, 32'h0000FFFF, 32'h00FF00FF, 32'h00000003};
        logic [31:0] vb [8] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h11111111,
                                32'h00000000, 32'h000000FF, 32'h00010001, 32'h00000005};
        logic        vc [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        vs [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] vS [8] = '{32'h00000000, 32'h80000000, 32'h7FFFFFFF, 32'h2345678A,
                                32'h00000000, 32'h000100FE, 32'h01000101, 32'hFFFFFFFE};
        logic        vC [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        vO [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] ra, rb;
        logic        rc, rs;
        b32.in_valid = 1'b0; b32.A = '0; b32.B = '0; b32.cin = 1'b0; b32.sub = 1'b0; b32.out_ready = 1'b1;
        rst32 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst32 = 1'b0;
        @(negedge clk);
        chk("rst_out_valid32", 32'(b32.out_valid), 32'd0);
        chk("rst_S32", b32.S, 32'd0);
        @(posedge clk); #1;
        fork
            forever begin @(posedge clk); #1 b32.out_ready = 1'($urandom_range(0, 1)); end
        join_none
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send32(va[i], vb[i], vc[i], vs[i], mk(vS[i], vC[i], vO[i]));
        end
        for (int i = 0; i < 150; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            send32(ra, rb, rc, rs, model32(ra, rb, rc, rs));
        end
        for (int n = 0; n < 200 && q32.size() != 0; n++) @(posedge clk);
        #1 chk("drain32", 32'(q32.size()), 32'd0);
        done32 = 1'b1;
    end

    initial begin
        fork
            wait (done16 && done32);
            #100000;
        join_any
        if (!(done16 && done32)) begin
            checks++; failures++;
            $display("FAIL run_timeout: got done16=%0b done32=%0b expected both 1", done16, done32);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
